// File: rtl/spike_count_decoder.sv
//------------------------------------------------------------------------------
// spike_count_decoder: windowed per-neuron spike counter with winner/tie readout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spike_count_decoder #(
  parameter int N_OUT = 2,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIN_W-1:0]       window_len,
  input  logic [N_OUT-1:0]       spikes_in,
  output logic [N_OUT*CNT_W-1:0] count_out,
  output logic [N_OUT-1:0]       winner,
  output logic                   tie,
  output logic                   sat,
  output logic                   valid
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t                        state_q;
  logic [N_OUT-1:0][CNT_W-1:0]   cnt_q;
  logic [N_OUT-1:0][CNT_W-1:0]   cnt_d;
  logic                          sat_q;
  logic                          sat_d;
  logic [WIN_W-1:0]              timer_q;
  logic [WIN_W-1:0]              len_q;
  logic [N_OUT-1:0]              winner_d;
  logic                          tie_d;
  logic                          last_cycle;
  logic [CNT_W-1:0]              max_val;
  int                            max_idx;

  // A zero length wraps to all-ones, giving the full 2^WIN_W cycle window.
  assign last_cycle = (timer_q == (len_q - WIN_W'(1)));

  always_comb begin
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    winner_d = '0;
    tie_d    = 1'b0;
    max_val  = '0;
    max_idx  = 0;
    for (int i = 0; i < N_OUT; i++) begin
      if (spikes_in[i]) begin
        if (cnt_q[i] == C_CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // Strict greater-than keeps the lowest index on equal maxima.
    max_val = cnt_d[0];
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt_d[i] > max_val) begin
        max_val = cnt_d[i];
        max_idx = i;
      end
    end
    if (max_val != '0) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (i == max_idx) begin
          winner_d[i] = 1'b1;
        end else if (cnt_d[i] == max_val) begin
          tie_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      timer_q   <= '0;
      len_q     <= '0;
      count_out <= '0;
      winner    <= '0;
      tie       <= 1'b0;
      sat       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_COUNT;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            timer_q <= '0;
            len_q   <= window_len;
          end
        end
        S_COUNT: begin
          if (last_cycle) begin
            count_out <= cnt_d;
            winner    <= winner_d;
            tie       <= tie_d;
            sat       <= sat_d;
            valid     <= 1'b1;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            timer_q   <= '0;
            len_q     <= window_len;
            state_q   <= en ? S_COUNT : S_IDLE;
          end else if (!en) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            timer_q <= '0;
          end else begin
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            timer_q <= timer_q + WIN_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spike_count_decoder.sv
//------------------------------------------------------------------------------
// tb_spike_count_decoder: scoreboard bench for the spike count decoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_count_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  window_len = 8'd4;
  logic [1:0]  spikes_in = 2'b00;
  logic [15:0] count_out;
  logic [1:0]  winner;
  logic        tie;
  logic        sat;
  logic        valid;

  spike_count_decoder #(.N_OUT(2), .CNT_W(8), .WIN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .window_len (window_len),
    .spikes_in  (spikes_in),
    .count_out  (count_out),
    .winner     (winner),
    .tie        (tie),
    .sat        (sat),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic [1:0]  win;
    logic        tie;
    logic        sat;
    int          cyc;
  } rep_t;

  rep_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] last_cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of the window behaviour, evaluated at each clock edge.
  int m_busy = 0;
  int m_len  = 0;
  int m_t    = 0;
  int m_c[2] = '{0, 0};
  int m_sat  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_t    = 0;
      m_c    = '{0, 0};
      m_sat  = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (m_busy == 0) begin
        if (en) begin
          m_busy = 1;
          m_t    = 0;
          m_c    = '{0, 0};
          m_sat  = 0;
          m_len  = (window_len == 0) ? 256 : int'(window_len);
        end
      end else if (m_t == m_len - 1 || en) begin
        for (int i = 0; i < 2; i++) begin
          if (spikes_in[i]) begin
            if (m_c[i] == 255) m_sat = 1;
            else m_c[i] = m_c[i] + 1;
          end
        end
        if (m_t == m_len - 1) begin
          rep_t r;
          int   mx;
          int   nmx;
          mx  = (m_c[0] > m_c[1]) ? m_c[0] : m_c[1];
          nmx = ((m_c[0] == mx) ? 1 : 0) + ((m_c[1] == mx) ? 1 : 0);
          r.cnt = {m_c[1][7:0], m_c[0][7:0]};
          r.win = (mx == 0) ? 2'b00 : ((m_c[0] == mx) ? 2'b01 : 2'b10);
          r.tie = (mx != 0) && (nmx > 1);
          r.sat = (m_sat != 0);
          r.cyc = cyc;
          exp_q.push_back(r);
          m_t   = 0;
          m_c   = '{0, 0};
          m_sat = 0;
          m_len = (window_len == 0) ? 256 : int'(window_len);
          m_busy = en ? 1 : 0;
        end else begin
          m_t++;
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(valid), 32'd0);
        end else begin
          rep_t r;
          r = exp_q.pop_front();
          check_eq("valid_cycle", 32'(cyc), 32'(r.cyc));
          check_eq("count_out", 32'(count_out), 32'(r.cnt));
          check_eq("winner", 32'(winner), 32'(r.win));
          check_eq("tie", 32'(tie), 32'(r.tie));
          check_eq("sat", 32'(sat), 32'(r.sat));
          last_cnt = r.cnt;
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check_eq("missing_valid", 32'(valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Park in IDLE, then raise en; the window begins after one ignored cycle.
  task automatic start_window(input logic [7:0] len);
    en = 1'b0;
    spikes_in = 2'b00;
    window_len = len;
    step(2);
    en = 1'b1;
    step(1);
  endtask

  task automatic apply(input logic [1:0] pat[$]);
    foreach (pat[i]) begin
      spikes_in = pat[i];
      step(1);
    end
  endtask

  initial begin
    step(3);
    check_eq("rst_count_out", 32'(count_out), 32'd0);
    check_eq("rst_winner", 32'(winner), 32'd0);
    check_eq("rst_flags", 32'({tie, sat, valid}), 32'd0);
    rst = 1'b0;

    // Window of 4 with neuron 0 firing every cycle, several windows back-to-back.
    start_window(8'd4);
    spikes_in = 2'b01;
    step(14);

    // Asynchronous reset mid-window clears the report at once.
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_count_out", 32'(count_out), 32'd0);
    check_eq("async_rst_winner", 32'(winner), 32'd0);
    check_eq("async_rst_flags", 32'({tie, sat, valid}), 32'd0);
    step(1);
    rst = 1'b0;
    step(7);

    // Equal counts 3/3 in a 5-cycle window, twice.
    start_window(8'd5);
    apply('{2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11});

    // Full 256-cycle window saturates neuron 1.
    start_window(8'd0);
    spikes_in = 2'b10;
    step(260);

    // Abort mid-window: no report, previous report held.
    start_window(8'd6);
    spikes_in = 2'b01;
    step(2);
    en = 1'b0;
    step(4);
    check_eq("abort_held_count", 32'(count_out), 32'(last_cnt));
    check_eq("abort_no_pending", 32'(exp_q.size()), 32'd0);
    en = 1'b1;
    step(1);
    spikes_in = 2'b11;
    step(8);

    // Window length change mid-window takes effect on the next window.
    start_window(8'd4);
    spikes_in = 2'b10;
    step(1);
    window_len = 8'd8;
    step(14);

    // Random lengths, spikes and occasional en drops.
    start_window(8'd3);
    for (int k = 0; k < 300; k++) begin
      spikes_in = 2'($urandom_range(0, 3));
      if (k % 17 == 0) window_len = 8'($urandom_range(1, 7));
      en = ($urandom_range(0, 19) != 0);
      step(1);
    end

    en = 1'b0;
    spikes_in = 2'b00;
    step(4);
    check_eq("pending_reports", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
